// File: rtl/synth_ram_2p.sv
// synth_ram_2p: flip-flop simple dual-port RAM on a single clock.
// One write port with byte-lane enables, one independent read port with a
// one- or two-stage read pipeline, a selectable read-during-write policy,
// a self-clearing FSM that zeroes the array after reset, and an error flag
// that qualifies reads whose address lies outside the array.
module synth_ram_2p #(
    parameter int WIDTH        = 32,  // multiple of 8
    parameter int WORDS        = 64,  // >= 2, any value
    parameter int ADDR_W       = 22,  // >= clog2(WORDS)
    parameter int READ_LATENCY = 1,   // 1 or 2
    parameter int RDW_MODE     = 0    // 0 = old data, 1 = write-first
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_busy,
    input  logic                 wr_en,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 rd_err
);

    localparam int BYTES = WIDTH / 8;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Address bound widened to the port width so comparisons use every
    // address bit: an address of WORDS or above must never alias low words.
    localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(WORDS);
    localparam logic [AW-1:0]     LAST_W  = AW'(WORDS - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t              state;
    logic [AW-1:0]       cnt;

    logic [WIDTH-1:0]    mem [WORDS];

    logic                ready;
    logic                wr_in_range;
    logic                rd_in_range;
    logic [AW-1:0]       wr_idx;
    logic [AW-1:0]       rd_idx;
    logic                wr_fire;
    logic                rd_fire;
    logic [WIDTH-1:0]    wr_old;
    logic [WIDTH-1:0]    wr_merged;
    logic [WIDTH-1:0]    rd_word;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [WIDTH-1:0]    mem_wdata;

    logic                s1_valid;
    logic                s1_err;
    logic [WIDTH-1:0]    s1_data;

    assign ready       = (state == READY);
    assign wr_in_range = (wr_addr < WORDS_A);
    assign rd_in_range = (rd_addr < WORDS_A);
    assign wr_idx      = wr_addr[AW-1:0];
    assign rd_idx      = rd_addr[AW-1:0];
    assign wr_fire     = ready && wr_en && wr_in_range;
    assign rd_fire     = ready && rd_en;

    // Byte-lane merge of the write data into the currently stored word, and
    // selection of the word a read captures this cycle.
    // NOTE: every signal driven here gets a value on every path before any
    // conditional logic, so no latch can be inferred.
    always_comb begin
        wr_old    = wr_in_range ? mem[wr_idx] : '0;
        wr_merged = wr_old;
        for (int i = 0; i < BYTES; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end

        rd_word = '0;
        if (rd_in_range) begin
            if ((RDW_MODE == 1) && wr_fire && (wr_idx == rd_idx)) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[rd_idx];
            end
        end
    end

    // Single array write port shared between the clear sweep and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_idx;
        mem_wdata = wr_merged;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    // Clear FSM: sweep every word to zero after reset, then hold READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST_W) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    state     <= READY;
                    init_busy <= 1'b0;
                end
                default: begin
                    state     <= CLEAR;
                    cnt       <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Storage array; contents are established by the clear sweep.
    // NOTE: the array has no reset branch so it maps onto plain enable flops;
    // the FSM zeroes it word by word instead. Sequential state always uses
    // non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // First read stage: capture the selected word when a read is accepted;
    // the data register holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            s1_err   <= rd_fire && !rd_in_range;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            // Second read stage: plain output register behind the first stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_err   <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= s1_valid;
                    rd_err   <= s1_valid && s1_err;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign rd_err   = s1_err;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_synth_ram_2p.sv
// tb_synth_ram_2p: drives two instances of synth_ram_2p (latency 1 / old-data
// and latency 2 / write-first) with identical directed and random traffic and
// compares both against a word-array reference model with a due-cycle queue.
module tb_synth_ram_2p;

    localparam int WORDS  = 64;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 22;

    typedef struct {
        int unsigned      due;
        logic [WIDTH-1:0] data;
        logic             err;
    } rd_t;

    logic               clk;
    logic               rst;
    logic               wr_en;
    logic [3:0]         wr_be;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;

    logic               init_busy0, init_busy1;
    logic [WIDTH-1:0]   rd_data0, rd_data1;
    logic               rd_valid0, rd_valid1;
    logic               rd_err0, rd_err1;

    int                 compared;
    int                 mismatched;

    logic [WIDTH-1:0]   ref_mem [WORDS];
    rd_t                q0[$];
    rd_t                q1[$];
    int                 clear_left;
    int unsigned        edge_n;
    logic [WIDTH-1:0]   last0, last1;

    synth_ram_2p #(
        .WIDTH(WIDTH), .WORDS(WORDS), .ADDR_W(ADDR_W),
        .READ_LATENCY(1), .RDW_MODE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .init_busy(init_busy0),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_err(rd_err0)
    );

    synth_ram_2p #(
        .WIDTH(WIDTH), .WORDS(WORDS), .ADDR_W(ADDR_W),
        .READ_LATENCY(2), .RDW_MODE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .init_busy(init_busy1),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_err(rd_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [3:0] be,
                                               input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    task automatic set_idle();
        wr_en = 1'b0; wr_be = 4'h0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic check_outputs();
        rd_t r;
        check("busy0", {31'b0, init_busy0}, {31'b0, rst || clear_left > 0});
        check("busy1", {31'b0, init_busy1}, {31'b0, rst || clear_left > 0});
        if (q0.size() > 0 && q0[0].due == edge_n) begin
            r = q0.pop_front();
            check("valid0", {31'b0, rd_valid0}, 32'd1);
            check("data0", rd_data0, r.data);
            check("err0", {31'b0, rd_err0}, {31'b0, r.err});
            last0 = r.data;
        end else begin
            check("idle_valid0", {31'b0, rd_valid0}, 32'd0);
            check("idle_err0", {31'b0, rd_err0}, 32'd0);
            check("hold_data0", rd_data0, last0);
        end
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            r = q1.pop_front();
            check("valid1", {31'b0, rd_valid1}, 32'd1);
            check("data1", rd_data1, r.data);
            check("err1", {31'b0, rd_err1}, {31'b0, r.err});
            last1 = r.data;
        end else begin
            check("idle_valid1", {31'b0, rd_valid1}, 32'd0);
            check("idle_err1", {31'b0, rd_err1}, 32'd0);
            check("hold_data1", rd_data1, last1);
        end
    endtask

    // One clock: apply the model's view of the edge, then compare outputs.
    task automatic cycle();
        logic [WIDTH-1:0] oldw, neww;
        logic             wr_ok;
        @(posedge clk);
        edge_n++;
        if (!rst) begin
            if (clear_left > 0) begin
                clear_left--;
            end else begin
                wr_ok = wr_en && (wr_addr < WORDS);
                if (rd_en) begin
                    if (rd_addr >= WORDS) begin
                        q0.push_back('{due: edge_n,     data: '0, err: 1'b1});
                        q1.push_back('{due: edge_n + 1, data: '0, err: 1'b1});
                    end else begin
                        oldw = ref_mem[int'(rd_addr)];
                        neww = (wr_ok && wr_addr == rd_addr) ? merge(oldw, wr_be, wr_data) : oldw;
                        q0.push_back('{due: edge_n,     data: oldw, err: 1'b0});
                        q1.push_back('{due: edge_n + 1, data: neww, err: 1'b0});
                    end
                end
                if (wr_ok) ref_mem[int'(wr_addr)] = merge(ref_mem[int'(wr_addr)], wr_be, wr_data);
            end
        end
        #1;
        check_outputs();
    endtask

    // Asynchronous reset assertion between edges; the model forgets everything.
    task automatic assert_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        clear_left = WORDS;
        last0 = '0;
        last1 = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        #1;
        check_outputs();
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        while (init_busy0 === 1'b1 && n < 200) begin
            cycle();
            n++;
        end
        check("clear_cycles", n, WORDS);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        edge_n     = 0;
        set_idle();
        #1;
        assert_reset();
        cycle();
        cycle();
        rst = 1'b0;

        // Clear length, with requests during the clear that must be ignored.
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 22'd3; wr_data = 32'hCAFEF00D;
        rd_en = 1'b1; rd_addr = 22'd3;
        count_clear();
        set_idle();

        // Every word reads zero after the clear.
        for (int a = 0; a < WORDS; a++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(a);
            cycle();
        end
        set_idle(); cycle(); cycle();

        // Byte-enable merge on address 5.
        wr_en = 1'b1; wr_addr = 22'd5; wr_be = 4'hF; wr_data = 32'hDEADBEEF; cycle();
        wr_be = 4'b0101; wr_data = 32'h11223344; cycle();
        wr_be = 4'h0; wr_data = 32'hFFFFFFFF; cycle();
        set_idle(); rd_en = 1'b1; rd_addr = 22'd5; cycle();
        set_idle(); cycle();
        check("merge_word", ref_mem[5], 32'hDE22BE44);
        check("merge_last0", rd_data0, 32'hDE22BE44);
        cycle();

        // Same-cycle write and read of address 9.
        wr_en = 1'b1; wr_addr = 22'd9; wr_be = 4'hF; wr_data = 32'hA5A5A5A5;
        rd_en = 1'b1; rd_addr = 22'd9; cycle();
        set_idle(); rd_en = 1'b1; rd_addr = 22'd9; cycle();
        set_idle(); cycle(); cycle();

        // Out-of-range read and write at address 64, then address 0.
        wr_en = 1'b1; wr_addr = 22'd64; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_addr = 22'd64; cycle();
        set_idle(); rd_en = 1'b1; rd_addr = 22'd0; cycle();
        rd_addr = 22'h3FFFFF; cycle();
        set_idle(); cycle(); cycle();

        // Back-to-back reads over addresses 0..7.
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_be = 4'hF; wr_addr = ADDR_W'(a); wr_data = $urandom; cycle();
        end
        set_idle();
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(a); cycle();
        end
        set_idle(); cycle(); cycle();

        // Random traffic, including out-of-range and colliding addresses.
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_be   = 4'($urandom);
            wr_addr = ADDR_W'($urandom_range(0, 69));
            wr_data = $urandom;
            rd_en   = ($urandom_range(0, 3) != 0);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 69));
            cycle();
        end

        // Reset with reads in flight: none of them may complete.
        set_idle(); rd_en = 1'b1; rd_addr = 22'd3; cycle();
        rd_addr = 22'd4; cycle();
        assert_reset();
        set_idle(); cycle(); cycle();
        rst = 1'b0;

        // Reset in the middle of the clear restarts it from word 0.
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_be = 4'hF; wr_addr = ADDR_W'(i); wr_data = $urandom;
            rd_en = 1'b1; rd_addr = ADDR_W'(i);
            cycle();
        end
        assert_reset();
        set_idle(); cycle();
        rst = 1'b0;
        count_clear();

        // Array is zero again after the restarted clear.
        for (int a = 0; a < WORDS; a++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(a);
            cycle();
        end
        set_idle(); cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
